// File: rtl/ctrl_config_rtc_pkg.sv
// Shared constants for the RTC configuration controller: mode codes, FSM
// encoding, BCD field limits and the month-length table used by FECHA_VALIDA_EN.
package ctrl_config_rtc_pkg;

    localparam logic [1:0] MODO_NORMAL = 2'b00;
    localparam logic [1:0] MODO_HORA   = 2'b01;
    localparam logic [1:0] MODO_FECHA  = 2'b10;
    localparam logic [1:0] MODO_TIMER  = 2'b11;

    localparam logic [1:0] ST_NORMAL = 2'd0;
    localparam logic [1:0] ST_CARGA  = 2'd1;
    localparam logic [1:0] ST_EDITA  = 2'd2;
    localparam logic [1:0] ST_SALIDA = 2'd3;

    // hora and timer share the seg/min/hora limits
    localparam logic [7:0] HMS_MIN      = 8'h00;
    localparam logic [7:0] HMS_C0_MAX   = 8'h59;
    localparam logic [7:0] HMS_C1_MAX   = 8'h59;
    localparam logic [7:0] HMS_C2_MAX   = 8'h23;
    localparam logic [7:0] FECHA_C0_MIN = 8'h01;
    localparam logic [7:0] FECHA_C0_MAX = 8'h31;
    localparam logic [7:0] FECHA_C1_MIN = 8'h01;
    localparam logic [7:0] FECHA_C1_MAX = 8'h12;
    localparam logic [7:0] FECHA_C2_MIN = 8'h00;
    localparam logic [7:0] FECHA_C2_MAX = 8'h99;

    // Byte k holds the BCD day count of month k+1 (February non-leap).
    localparam logic [95:0] DIAS_MES = {8'h31, 8'h30, 8'h31, 8'h30, 8'h31, 8'h31,
                                        8'h30, 8'h31, 8'h30, 8'h31, 8'h28, 8'h31};

    function automatic logic [7:0] campo_min(input logic [1:0] modo, input logic [1:0] campo);
        if (modo != MODO_FECHA) return HMS_MIN;
        if (campo == 2'd0) return FECHA_C0_MIN;
        if (campo == 2'd1) return FECHA_C1_MIN;
        return FECHA_C2_MIN;
    endfunction

    function automatic logic [7:0] campo_max(input logic [1:0] modo, input logic [1:0] campo);
        if (modo == MODO_FECHA) begin
            if (campo == 2'd0) return FECHA_C0_MAX;
            if (campo == 2'd1) return FECHA_C1_MAX;
            return FECHA_C2_MAX;
        end
        if (campo == 2'd0) return HMS_C0_MAX;
        if (campo == 2'd1) return HMS_C1_MAX;
        return HMS_C2_MAX;
    endfunction

    // A two-digit BCD year is a multiple of 4 when tens even & units 0/4/8, or tens odd & units 2/6.
    function automatic logic bcd_div4(input logic [7:0] jahr);
        if (jahr[4] == 1'b0) return (jahr[1:0] == 2'b00) && (jahr[3:0] <= 4'd9);
        return (jahr[3:0] == 4'd2) || (jahr[3:0] == 4'd6);
    endfunction

    function automatic logic [7:0] dias_max(input logic [7:0] mes, input logic [7:0] jahr);
        logic [3:0] idx;
        logic [7:0] dias;
        dias = 8'h31;
        idx  = 4'd0;
        if (mes >= 8'h01 && mes <= 8'h12 && mes[3:0] <= 4'd9) begin
            idx  = mes[4] ? mes[3:0] + 4'd9 : mes[3:0] - 4'd1;
            dias = DIAS_MES[{idx, 3'b000} +: 8];
            if (mes == 8'h02 && bcd_div4(jahr)) dias = 8'h29;
        end
        return dias;
    endfunction

endpackage

// File: rtl/ctrl_config_rtc_bcd_inc_dec.sv
// Combinational BCD +1/-1 with wrap between min and max; an invalid input
// (bad nibble or out of range) snaps to min on increment and to max on decrement.
module ctrl_config_rtc_bcd_inc_dec (
    input  logic [7:0] valor,
    input  logic [7:0] min_v,
    input  logic [7:0] max_v,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] siguiente
);

    logic valido;

    always_comb begin
        valido = (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9) &&
                 (valor >= min_v) && (valor <= max_v);
        siguiente = valor;
        if (inc && !dec) begin
            if (!valido || valor == max_v)  siguiente = min_v;
            else if (valor[3:0] == 4'd9)    siguiente = {valor[7:4] + 4'd1, 4'd0};
            else                            siguiente = valor + 8'd1;
        end else if (dec && !inc) begin
            if (!valido || valor == min_v)  siguiente = max_v;
            else if (valor[3:0] == 4'd0)    siguiente = {valor[7:4] - 4'd1, 4'd9};
            else                            siguiente = valor - 8'd1;
        end
    end

endmodule

// File: rtl/ctrl_config_rtc.sv
// RTC configuration controller: button edges -> config_mode, cursor and BCD editing
// with inactivity auto-exit. Define FECHA_VALIDA_EN for month/leap-aware day limits.
module ctrl_config_rtc
    import ctrl_config_rtc_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 1000000000,
    parameter int ANCHO_TMO      = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_hora,
    input  logic       btn_fecha,
    input  logic       btn_timer,
    input  logic       btn_izq,
    input  logic       btn_der,
    input  logic       btn_arriba,
    input  logic       btn_abajo,
    input  logic       btn_salir,
    input  logic [7:0] actual_c0,
    input  logic [7:0] actual_c1,
    input  logic [7:0] actual_c2,
    output logic [1:0] config_mode,
    output logic [1:0] campo_sel,
    output logic [7:0] valor_c0,
    output logic [7:0] valor_c1,
    output logic [7:0] valor_c2,
    output logic       fin_config,
    output logic [1:0] estado_dbg
);

    localparam int B_HORA = 0, B_FECHA = 1, B_TIMER = 2, B_IZQ = 3;
    localparam int B_DER = 4, B_ARRIBA = 5, B_ABAJO = 6, B_SALIR = 7;
    localparam logic [ANCHO_TMO-1:0] TMO_LIM = ANCHO_TMO'(TIMEOUT_CICLOS - 1);

    logic [7:0]           btn_sync, btn_prev, ev;
    logic [1:0]           estado;
    logic [ANCHO_TMO-1:0] cnt;
    logic                 cursor_ev, valor_ev, tmo_hit;
    logic [7:0]           sel_val, sel_min, sel_max, nuevo;
    logic [7:0]           nv0, nv1, nv2;

    assign ev        = btn_sync & ~btn_prev;
    assign cursor_ev = ev[B_IZQ] ^ ev[B_DER];
    assign valor_ev  = ev[B_ARRIBA] ^ ev[B_ABAJO];
    assign tmo_hit   = (TIMEOUT_CICLOS != 0) && (cnt == TMO_LIM);
    assign fin_config = (estado == ST_SALIDA);
    assign estado_dbg = estado;

    always_comb begin
        case (campo_sel)
            2'd0:    sel_val = valor_c0;
            2'd1:    sel_val = valor_c1;
            default: sel_val = valor_c2;
        endcase
        sel_min = campo_min(config_mode, campo_sel);
        sel_max = campo_max(config_mode, campo_sel);
`ifdef FECHA_VALIDA_EN
        if (config_mode == MODO_FECHA && campo_sel == 2'd0)
            sel_max = dias_max(valor_c1, valor_c2);
`endif
    end

    ctrl_config_rtc_bcd_inc_dec u_bcd (
        .valor     (sel_val),
        .min_v     (sel_min),
        .max_v     (sel_max),
        .inc       (ev[B_ARRIBA]),
        .dec       (ev[B_ABAJO]),
        .siguiente (nuevo)
    );

    // Edited field written back through the cursor; a mes/jahr edit may pull dia down.
    always_comb begin
        nv0 = valor_c0;
        nv1 = valor_c1;
        nv2 = valor_c2;
        if (valor_ev) begin
            case (campo_sel)
                2'd0:    nv0 = nuevo;
                2'd1:    nv1 = nuevo;
                default: nv2 = nuevo;
            endcase
        end
`ifdef FECHA_VALIDA_EN
        if (config_mode == MODO_FECHA && valor_ev && campo_sel != 2'd0 &&
            nv0 > dias_max(nv1, nv2))
            nv0 = dias_max(nv1, nv2);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync    <= 8'h00;
            btn_prev    <= 8'h00;
            estado      <= ST_NORMAL;
            config_mode <= MODO_NORMAL;
            campo_sel   <= 2'd0;
            valor_c0    <= 8'h00;
            valor_c1    <= 8'h00;
            valor_c2    <= 8'h00;
            cnt         <= '0;
        end else begin
            btn_sync <= {btn_salir, btn_abajo, btn_arriba, btn_der,
                         btn_izq, btn_timer, btn_fecha, btn_hora};
            btn_prev <= btn_sync;
            case (estado)
                ST_NORMAL: begin
                    if (ev[B_HORA]) begin
                        config_mode <= MODO_HORA;
                        estado      <= ST_CARGA;
                    end else if (ev[B_FECHA]) begin
                        config_mode <= MODO_FECHA;
                        estado      <= ST_CARGA;
                    end else if (ev[B_TIMER]) begin
                        config_mode <= MODO_TIMER;
                        estado      <= ST_CARGA;
                    end
                end
                ST_CARGA: begin
                    valor_c0  <= actual_c0;
                    valor_c1  <= actual_c1;
                    valor_c2  <= actual_c2;
                    campo_sel <= 2'd0;
                    cnt       <= '0;
                    estado    <= ST_EDITA;
                end
                ST_EDITA: begin
                    if (ev[B_SALIR] || tmo_hit) begin
                        estado <= ST_SALIDA;
                    end else begin
                        if (cursor_ev) begin
                            if (ev[B_IZQ]) campo_sel <= (campo_sel == 2'd0) ? 2'd2 : campo_sel - 2'd1;
                            else           campo_sel <= (campo_sel == 2'd2) ? 2'd0 : campo_sel + 2'd1;
                        end
                        valor_c0 <= nv0;
                        valor_c1 <= nv1;
                        valor_c2 <= nv2;
                        cnt      <= (cursor_ev || valor_ev) ? '0 : cnt + ANCHO_TMO'(1);
                    end
                end
                default: begin
                    config_mode <= MODO_NORMAL;
                    estado      <= ST_NORMAL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_config_rtc.sv
// Directed bench for ctrl_config_rtc: a decimal-arithmetic model of the editing
// rules is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_ctrl_config_rtc;
    localparam int TMO = 16;
    localparam int B_HORA = 0, B_FECHA = 1, B_TIMER = 2, B_IZQ = 3;
    localparam int B_DER = 4, B_UP = 5, B_DN = 6, B_SALIR = 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] btns;
    logic [7:0] grp [4][3];
    logic [7:0] actual_c0, actual_c1, actual_c2;
    logic [1:0] config_mode, campo_sel, estado_dbg;
    logic [7:0] valor_c0, valor_c1, valor_c2;
    logic       fin_config;

    // Expected-state model
    logic [1:0] e_mode, e_cur;
    logic [7:0] e_val [3];
    logic       e_fin;
    bit         phase_edit, leaving, armed, load_pending;
    int         t_last, cyc, n_vec, n_err;

    always #5 clk = ~clk;

    // External register-bank mux: presents the group chosen by config_mode.
    assign actual_c0 = grp[config_mode][0];
    assign actual_c1 = grp[config_mode][1];
    assign actual_c2 = grp[config_mode][2];

    ctrl_config_rtc #(.TIMEOUT_CICLOS(TMO), .ANCHO_TMO(30)) dut (
        .clk(clk), .reset_n(reset_n),
        .btn_hora(btns[B_HORA]), .btn_fecha(btns[B_FECHA]), .btn_timer(btns[B_TIMER]),
        .btn_izq(btns[B_IZQ]), .btn_der(btns[B_DER]), .btn_arriba(btns[B_UP]),
        .btn_abajo(btns[B_DN]), .btn_salir(btns[B_SALIR]),
        .actual_c0(actual_c0), .actual_c1(actual_c1), .actual_c2(actual_c2),
        .config_mode(config_mode), .campo_sel(campo_sel),
        .valor_c0(valor_c0), .valor_c1(valor_c1), .valor_c2(valor_c2),
        .fin_config(fin_config), .estado_dbg(estado_dbg)
    );

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic int day_limit(input int mes, input int jahr);
`ifdef FECHA_VALIDA_EN
        if (mes == 2) return (jahr % 4 == 0) ? 29 : 28;
        if (mes == 4 || mes == 6 || mes == 9 || mes == 11) return 30;
`endif
        return (mes >= 0 && jahr >= 0) ? 31 : 31;
    endfunction

    function automatic int fmin(input logic [1:0] mode, input int f);
        if (mode == 2'b10) return (f == 2) ? 0 : 1;
        return 0;
    endfunction

    function automatic int fmax(input logic [1:0] mode, input int f, input logic [7:0] mes, input logic [7:0] jahr);
        if (mode == 2'b10) begin
            if (f == 0) return day_limit(bcd2int(mes), bcd2int(jahr));
            return (f == 1) ? 12 : 99;
        end
        return (f == 2) ? 23 : 59;
    endfunction

    function automatic logic [7:0] step(input logic [7:0] v, input bit up, input int lo, input int hi);
        int n;
        n = bcd2int(v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || n < lo || n > hi) return int2bcd(up ? lo : hi);
        if (up) return int2bcd((n == hi) ? lo : n + 1);
        return int2bcd((n == lo) ? hi : n - 1);
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        check("config_mode", {6'b0, config_mode}, {6'b0, e_mode});
        check("campo_sel", {6'b0, campo_sel}, {6'b0, e_cur});
        check("valor_c0", valor_c0, e_val[0]);
        check("valor_c1", valor_c1, e_val[1]);
        check("valor_c2", valor_c2, e_val[2]);
        check("fin_config", {7'b0, fin_config}, {7'b0, e_fin});
    endtask

    // One clock: compare after the rising edge, return at the falling edge with
    // the exit rules (salir or inactivity) applied to the model.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #3;
        compare_all();
        @(negedge clk);
        if (leaving) begin
            e_fin = 1'b0; e_mode = 2'b00; leaving = 0;
        end else if (armed && cyc + 1 == t_last + TMO) begin
            e_fin = 1'b1; leaving = 1; armed = 0; phase_edit = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_apply(input logic [7:0] m);
        int old;
        bit acc;
        if (!phase_edit && !leaving) begin
            if (m[B_HORA])       begin e_mode = 2'b01; load_pending = 1; end
            else if (m[B_FECHA]) begin e_mode = 2'b10; load_pending = 1; end
            else if (m[B_TIMER]) begin e_mode = 2'b11; load_pending = 1; end
        end else if (phase_edit) begin
            if (m[B_SALIR]) begin
                e_fin = 1'b1; leaving = 1; armed = 0; phase_edit = 0;
            end else begin
                acc = 0;
                old = int'(e_cur);
                if (m[B_IZQ] ^ m[B_DER]) begin
                    e_cur = 2'(m[B_IZQ] ? (old + 2) % 3 : (old + 1) % 3);
                    acc = 1;
                end
                if (m[B_UP] ^ m[B_DN]) begin
                    e_val[old] = step(e_val[old], m[B_UP], fmin(e_mode, old),
                                      fmax(e_mode, old, e_val[1], e_val[2]));
                    if (e_mode == 2'b10 && old != 0 &&
                        bcd2int(e_val[0]) > day_limit(bcd2int(e_val[1]), bcd2int(e_val[2])))
                        e_val[0] = int2bcd(day_limit(bcd2int(e_val[1]), bcd2int(e_val[2])));
                    acc = 1;
                end
                if (acc) t_last = cyc + 1;
            end
        end
    endtask

    // One-cycle button pulse; returns once the resulting outputs have been compared.
    task automatic press(input logic [7:0] m);
        btns = btns | m;
        tick();
        btns = btns & ~m;
        model_apply(m);
        tick();
        if (load_pending) begin
            for (int f = 0; f < 3; f++) e_val[f] = grp[e_mode][f];
            e_cur = 2'd0; armed = 1; phase_edit = 1; load_pending = 0;
            t_last = cyc + 1;
            tick();
        end
    endtask

    task automatic model_reset();
        e_mode = 2'b00; e_cur = 2'd0; e_fin = 1'b0;
        for (int f = 0; f < 3; f++) e_val[f] = 8'h00;
        phase_edit = 0; leaving = 0; armed = 0; load_pending = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; t_last = 0;
        btns = 8'h00; reset_n = 1'b0;
        model_reset();
        for (int g = 0; g < 4; g++) for (int f = 0; f < 3; f++) grp[g][f] = 8'h00;
        grp[1][0] = 8'h59; grp[1][1] = 8'h59; grp[1][2] = 8'h23;
        grp[2][0] = 8'h01; grp[2][1] = 8'h12; grp[2][2] = 8'h00;
        grp[3][0] = 8'h7A; grp[3][1] = 8'h60; grp[3][2] = 8'h12;

        idle(2);
        check("rst_config_mode", {6'b0, config_mode}, 8'h00);
        check("rst_valor_c1", valor_c1, 8'h00);
        reset_n = 1'b1;
        tick();

        // hora: wraps at field maxima, cursor wraps both ways
        press(8'h01 << B_HORA);
        check("hora_mode", {6'b0, config_mode}, 8'h01);
        check("hora_load_c0", valor_c0, 8'h59);
        check("hora_load_c2", valor_c2, 8'h23);
        press(8'h01 << B_IZQ);
        check("izq_wrap", {6'b0, campo_sel}, 8'h02);
        press(8'h01 << B_UP);
        check("hora_c2_wrap", valor_c2, 8'h00);
        press(8'h01 << B_DER);
        press(8'h01 << B_DER);
        press(8'h01 << B_UP);
        check("hora_c1_wrap", valor_c1, 8'h00);
        press((8'h01 << B_IZQ) | (8'h01 << B_UP));
        check("same_cycle_c1", valor_c1, 8'h01);
        check("same_cycle_cur", {6'b0, campo_sel}, 8'h00);
        press(8'h01 << B_DN);
        check("hora_c0_dec", valor_c0, 8'h58);
        press(8'h01 << B_SALIR);
        check("salir_fin", {7'b0, fin_config}, 8'h01);
        check("salir_mode_held", {6'b0, config_mode}, 8'h01);
        tick();
        check("salir_fin_drop", {7'b0, fin_config}, 8'h00);
        check("salir_mode_clear", {6'b0, config_mode}, 8'h00);

        // fecha: wraps at min/max of each field
        press(8'h01 << B_FECHA);
        press(8'h01 << B_DN);
        check("fecha_dia_wrap", valor_c0, 8'h31);
        press(8'h01 << B_DER);
        press(8'h01 << B_UP);
        check("fecha_mes_wrap", valor_c1, 8'h01);
        press(8'h01 << B_DER);
        press(8'h01 << B_DN);
        check("fecha_jahr_wrap", valor_c2, 8'h99);
        press(8'h01 << B_SALIR);
        idle(2);

        // timer: ignored pair, held mode button, invalid loads, inactivity exit
        press(8'h01 << B_TIMER);
        press((8'h01 << B_UP) | (8'h01 << B_DN));
        check("pair_ignored", valor_c0, 8'h7A);
        btns[B_TIMER] = 1'b1;
        repeat (5) begin
            press(8'h01 << B_IZQ);
            idle(8);
            press(8'h01 << B_DER);
            idle(8);
        end
        btns[B_TIMER] = 1'b0;
        tick();
        check("held_mode", {6'b0, config_mode}, 8'h03);
        press(8'h01 << B_UP);
        check("invalid_up_min", valor_c0, 8'h00);
        press(8'h01 << B_DER);
        press(8'h01 << B_DN);
        check("invalid_dn_max", valor_c1, 8'h59);
        idle(20);
        check("timeout_exit", {6'b0, config_mode}, 8'h00);

        // mode priority, then asynchronous reset mid-edit
        grp[1][0] = 8'h12; grp[1][1] = 8'h37; grp[1][2] = 8'h08;
        press((8'h01 << B_HORA) | (8'h01 << B_FECHA) | (8'h01 << B_TIMER));
        check("priority_hora", {6'b0, config_mode}, 8'h01);
        check("pre_reset_c1", valor_c1, 8'h37);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_mode", {6'b0, config_mode}, 8'h00);
        check("async_rst_cur", {6'b0, campo_sel}, 8'h00);
        check("async_rst_c0", valor_c0, 8'h00);
        check("async_rst_c1", valor_c1, 8'h00);
        check("async_rst_c2", valor_c2, 8'h00);
        check("async_rst_fin", {7'b0, fin_config}, 8'h00);
        idle(2);
        reset_n = 1'b1;
        tick();

        // month change with dia at 31: clamps only when day validation is built in
        grp[2][0] = 8'h31; grp[2][1] = 8'h01; grp[2][2] = 8'h23;
        press(8'h01 << B_FECHA);
        press(8'h01 << B_DER);
        press(8'h01 << B_UP);
        check("feb_mes", valor_c1, 8'h02);
`ifdef FECHA_VALIDA_EN
        check("feb_dia_j23", valor_c0, 8'h28);
`else
        check("feb_dia_j23", valor_c0, 8'h31);
`endif
        press(8'h01 << B_SALIR);
        idle(2);
        grp[2][2] = 8'h24;
        press(8'h01 << B_FECHA);
        press(8'h01 << B_DER);
        press(8'h01 << B_UP);
`ifdef FECHA_VALIDA_EN
        check("feb_dia_j24", valor_c0, 8'h29);
`else
        check("feb_dia_j24", valor_c0, 8'h31);
`endif
        press(8'h01 << B_SALIR);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
